program_sequencer: RTL

PROGRAM_SEQUENCER -- requirements
Module: program_sequencer

---
 rtl/program_sequencer_if.sv | 30 +++
 rtl/program_sequencer.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/program_sequencer_if.sv
// Program-sequencer bus: the program-load port, the processor status inputs, the
// switch-data/step-clock outputs and the FIFO/sequencer status flags.
`timescale 1ns/1ps
interface program_sequencer_if;
  logic [9:0] WR_Data;
  logic       WR_En;
  logic       Run;
  logic [1:0] Timestep;
  logic       Ext;
  logic       Done;
  logic [9:0] Data_Out;
  logic       Step_Pulse;
  logic [3:0] Count;
  logic       Full;
  logic       Empty;
  logic       Busy;
  logic       Prog_Done;
  logic       Overflow;
  logic       Underflow;

  modport master (
    output WR_Data, WR_En, Run, Timestep, Ext, Done,
    input  Data_Out, Step_Pulse, Count, Full, Empty, Busy, Prog_Done, Overflow, Underflow
  );

  modport slave (
    input  WR_Data, WR_En, Run, Timestep, Ext, Done,
    output Data_Out, Step_Pulse, Count, Full, Empty, Busy, Prog_Done, Overflow, Underflow
  );
endinterface

// File: rtl/program_sequencer.sv
// Feeds queued program words to a simple processor's switch input and generates its
// step clock, popping a word only on steps where the processor consumes data.
`timescale 1ns/1ps
module program_sequencer #(
  parameter int unsigned DEPTH     = 8,
  parameter int unsigned SETUP_CYC = 2,
  parameter int unsigned PULSE_CYC = 4,
  parameter int unsigned GAP_CYC   = 4
) (
  input  logic               Clock_50MHz,
  input  logic               Reset_n,
  program_sequencer_if.slave bus
);

  localparam int unsigned AW      = $clog2(DEPTH);
  localparam int unsigned CNTW    = AW + 1;
  localparam int unsigned MAX_A   = (SETUP_CYC > PULSE_CYC) ? SETUP_CYC : PULSE_CYC;
  localparam int unsigned MAX_CYC = (MAX_A > GAP_CYC) ? MAX_A : GAP_CYC;
  localparam int unsigned CW      = $clog2(MAX_CYC + 1);

  typedef enum logic [1:0] {IDLE, PRESENT, PULSE, GAP} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            need_q, need_d;
  logic            step_pulse_q, step_pulse_d;
  logic            busy_q, busy_d;
  logic            prog_done_q, prog_done_d;
  logic            overflow_q, overflow_d;
  logic            underflow_q, underflow_d;
  logic            run_q, run_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [CNTW-1:0] count_q, count_d;
  logic            full_q, full_d;
  logic            empty_q, empty_d;
  logic [9:0]      mem_q [DEPTH];

  logic need_now_c;
  logic pop_c;
  logic wr_ok_c;
  logic underflow_set_c;
  logic run_rise_c;

  // Sequencer: present data, pulse the step clock, then gap and decide what follows.
  always_comb begin
    state_d         = state_q;
    cnt_d           = cnt_q;
    need_d          = need_q;
    prog_done_d     = 1'b0;
    underflow_set_c = 1'b0;
    pop_c           = 1'b0;
    need_now_c      = (bus.Timestep == 2'd0) | bus.Ext;
    case (state_q)
      IDLE: begin
        if (bus.Run && !empty_q) begin
          state_d = PRESENT;
          cnt_d   = '0;
        end
      end
      PRESENT: begin
        if (cnt_q == CW'(SETUP_CYC - 1)) begin
          need_d = need_now_c;
          cnt_d  = '0;
          // Processor wants a word but the program has run out.
          if (need_now_c && empty_q) begin
            state_d = IDLE;
            if (bus.Timestep == 2'd0) prog_done_d = 1'b1;
            else                      underflow_set_c = 1'b1;
          end else begin
            state_d = PULSE;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      PULSE: begin
        if (cnt_q == CW'(PULSE_CYC - 1)) begin
          state_d = GAP;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      GAP: begin
        // The processor latched the word on the falling step edge; retire it now.
        pop_c = (cnt_q == '0) && need_q && !empty_q;
        if (cnt_q == CW'(GAP_CYC - 1)) begin
          cnt_d = '0;
          if (!bus.Run && (bus.Done || bus.Timestep == 2'd0)) begin
            state_d = IDLE;
          end else if (bus.Done && empty_q) begin
            state_d     = IDLE;
            prog_done_d = 1'b1;
          end else begin
            state_d = PRESENT;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // FIFO bookkeeping and sticky error flags.
  always_comb begin
    wr_ok_c      = bus.WR_En && (!full_q || pop_c);
    rd_ptr_d     = rd_ptr_q + AW'(pop_c);
    wr_ptr_d     = wr_ptr_q + AW'(wr_ok_c);
    count_d      = count_q + CNTW'(wr_ok_c) - CNTW'(pop_c);
    full_d       = (count_d == CNTW'(DEPTH));
    empty_d      = (count_d == '0);
    run_rise_c   = bus.Run && !run_q && (state_q == IDLE);
    run_d        = bus.Run;
    overflow_d   = overflow_q;
    underflow_d  = underflow_q;
    if (run_rise_c) begin
      overflow_d  = 1'b0;
      underflow_d = 1'b0;
    end
    if (bus.WR_En && full_q && !pop_c) overflow_d = 1'b1;
    if (underflow_set_c)               underflow_d = 1'b1;
    step_pulse_d = (state_d == PULSE);
    busy_d       = (state_d != IDLE);
  end

  always_ff @(posedge Clock_50MHz or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      need_q       <= 1'b0;
      step_pulse_q <= 1'b0;
      busy_q       <= 1'b0;
      prog_done_q  <= 1'b0;
      overflow_q   <= 1'b0;
      underflow_q  <= 1'b0;
      run_q        <= 1'b0;
      rd_ptr_q     <= '0;
      wr_ptr_q     <= '0;
      count_q      <= '0;
      full_q       <= 1'b0;
      empty_q      <= 1'b1;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      need_q       <= need_d;
      step_pulse_q <= step_pulse_d;
      busy_q       <= busy_d;
      prog_done_q  <= prog_done_d;
      overflow_q   <= overflow_d;
      underflow_q  <= underflow_d;
      run_q        <= run_d;
      rd_ptr_q     <= rd_ptr_d;
      wr_ptr_q     <= wr_ptr_d;
      count_q      <= count_d;
      full_q       <= full_d;
      empty_q      <= empty_d;
    end
  end

  always_ff @(posedge Clock_50MHz) begin
    if (wr_ok_c) mem_q[wr_ptr_q] <= bus.WR_Data;
  end

  assign bus.Data_Out   = empty_q ? 10'd0 : mem_q[rd_ptr_q];
  assign bus.Step_Pulse = step_pulse_q;
  assign bus.Count      = 4'(count_q);
  assign bus.Full       = full_q;
  assign bus.Empty      = empty_q;
  assign bus.Busy       = busy_q;
  assign bus.Prog_Done  = prog_done_q;
  assign bus.Overflow   = overflow_q;
  assign bus.Underflow  = underflow_q;

endmodule
